unified_mem: RTL and testbench



---
 rtl/unified_mem.sv | 150 +++++++++++++++
 tb/tb_unified_mem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem.sv
// Line-granular unified backing memory serving I/D cache fills and evictions.
// Optional protocol checker enabled by defining UMEM_PROTO_CHK_EN.
module unified_mem #(
   parameter int ADDR_W  = 16,
   parameter int LINE_W  = 64,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              u_re,
   input  logic              u_we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LINE_W-1:0] wr_line,
   output logic [LINE_W-1:0] rd_line,
   output logic              u_rdy,
   output logic              busy,
   output logic              proto_err,
   output logic [1:0]        dbg_state
);

   // Handshake: the requester raises u_re or u_we with addr/wr_line and holds
   // them until u_rdy; a request is accepted at the first rising edge seen in
   // IDLE, inputs are ignored until the DONE cycle, and u_rdy is a one-cycle
   // completion pulse during which the requester may present its next request.

   localparam int IDX_W = ADDR_W - 2;
   localparam int DEPTH = 1 << IDX_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic             accept;
   logic             access;
   logic             op_wr;
   logic [IDX_W-1:0] idx;
   logic [LINE_W-1:0] wdata;
   logic [LINE_W-1:0] mem [DEPTH];

   // Word-select bits never affect a line-granular access.
   logic unused_addr_lo;
   assign unused_addr_lo = ^addr[1:0];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      access    = 1'b0;
      case (state)
         S_IDLE: begin
            if (u_re || u_we) begin
               accept    = 1'b1;
               state_nxt = S_BUSY;
               cnt_nxt   = 4'(LATENCY - 1);
            end
         end
         S_BUSY: begin
            if (cnt == 4'd0) begin
               access    = 1'b1;
               state_nxt = S_DONE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         u_rdy   <= 1'b0;
         rd_line <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         u_rdy <= access;
         if (access && !op_wr) begin
            rd_line <= mem[idx];
         end
      end
   end

   // Request is captured at accept so later input changes cannot leak in.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_wr <= 1'b0;
         idx   <= '0;
         wdata <= '0;
      end else if (accept) begin
         op_wr <= u_we;
         idx   <= addr[ADDR_W-1:2];
         wdata <= wr_line;
      end
   end

   // Array is not reset; a reset on the completing edge suppresses the write.
   always_ff @(posedge clk) begin
      if (rst_n && access && op_wr) begin
         mem[idx] <= wdata;
      end
   end

   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

`ifdef UMEM_PROTO_CHK_EN
   logic              prev_re;
   logic              prev_we;
   logic [ADDR_W-1:0] prev_addr;
   logic              viol;

   // Inputs must stay stable from accept until completion.
   always_comb begin
      viol = u_re && u_we;
      if (state == S_BUSY) begin
         if ((u_re != prev_re) || (u_we != prev_we) || (addr != prev_addr)) begin
            viol = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_re   <= 1'b0;
         prev_we   <= 1'b0;
         prev_addr <= '0;
         proto_err <= 1'b0;
      end else begin
         prev_re   <= u_re;
         prev_we   <= u_we;
         prev_addr <= addr;
         proto_err <= proto_err | viol;
      end
   end
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem.sv
// Randomized scoreboard bench for unified_mem: driver pushes expected
// completions (cycle and read data), a negedge monitor pops and compares.
module tb_unified_mem;

  localparam int AW  = 16;
  localparam int LW  = 64;
  localparam int LAT = 4;

  typedef struct {
    int              acc;
    int              rdy;
    bit              is_rd;
    logic [LW-1:0]   data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          u_re = 1'b0;
  logic          u_we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wr_line = '0;
  logic [LW-1:0] rd_line;
  logic          u_rdy;
  logic          busy;
  logic          proto_err;
  logic [1:0]    dbg_state;

  unified_mem #(.ADDR_W(AW), .LINE_W(LW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .u_re(u_re), .u_we(u_we), .addr(addr),
    .wr_line(wr_line), .rd_line(rd_line), .u_rdy(u_rdy), .busy(busy),
    .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t          exp_q[$];
  logic [LW-1:0] mem_m [int];
  logic [LW-1:0] last_rd = '0;
  int            free_edge = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && cyc >= exp_q[0].acc && cyc <= exp_q[0].rdy)
        chk("busy_in_flight", LW'(busy), LW'(1'b1));
      if (u_rdy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_u_rdy", LW'(u_rdy), LW'(1'b0));
        end else begin
          exp_t h;
          h = exp_q.pop_front();
          chk("u_rdy_cycle", LW'(cyc), LW'(h.rdy));
          if (h.is_rd) begin
            chk("rd_line", rd_line, h.data);
            last_rd = h.data;
          end else begin
            chk("rd_line_hold_wr", rd_line, last_rd);
          end
        end
      end else begin
        chk("rd_line_hold", rd_line, last_rd);
        if (exp_q.size() > 0 && cyc > exp_q[0].rdy) begin
          chk("missing_u_rdy", LW'(u_rdy), LW'(1'b1));
          void'(exp_q.pop_front());
        end
      end
`ifndef UMEM_PROTO_CHK_EN
      chk("proto_err_tied", LW'(proto_err), LW'(1'b0));
`endif
    end
  end

  // driver tasks (called and return at a negedge)
  task automatic reset_dut(input int n);
    rst_n = 1'b0;
    u_re = 1'b0;
    u_we = 1'b0;
    last_rd = '0;
    exp_q.delete();
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    free_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      u_re = 1'b0;
      u_we = 1'b0;
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic req(input bit wr, input bit both, input logic [AW-1:0] a,
                     input logic [LW-1:0] d, input bit mid_chg);
    exp_t e;
    int   key;
    bit   seen;
    u_re = !wr || both;
    u_we = wr || both;
    addr = a;
    wr_line = d;
    key = int'(a[AW-1:2]);
    e.acc = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    e.rdy = e.acc + LAT;
    e.is_rd = !(wr || both);
    if (e.is_rd) begin
      e.data = mem_m.exists(key) ? mem_m[key] : '0;
    end else begin
      mem_m[key] = d;
      e.data = d;
    end
    free_edge = e.acc + LAT + 2;
    exp_q.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (u_rdy) begin
        seen = 1'b1;
        break;
      end
      if (i == 0 && both) u_re = 1'b0;
      if (i == 0 && mid_chg) begin
        addr = a + 16'h0010;
        wr_line = ~d;
      end
    end
    if (!seen) chk("req_timeout", LW'(seen), LW'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    @(negedge clk);
    reset_dut(2);
    chk("rst_u_rdy", LW'(u_rdy), LW'(1'b0));
    chk("rst_busy", LW'(busy), LW'(1'b0));
    chk("rst_proto_err", LW'(proto_err), LW'(1'b0));
    chk("rst_rd_line", rd_line, '0);
    chk("rst_state", LW'(dbg_state), LW'(2'd0));

    // write then read the same line via different word offsets
    req(1'b1, 1'b0, 16'h0104, 64'h1111_2222_3333_4444, 1'b0);
    idle(2);
    req(1'b0, 1'b0, 16'h0107, '0, 1'b0);
    idle(3);

    // evict-then-fill: read presented in the u_rdy cycle of the write
    req(1'b1, 1'b0, 16'h0300, 64'hCAFE_0300_0000_0003, 1'b0);
    idle(1);
    req(1'b1, 1'b0, 16'h0200, 64'hDEAD_BEEF_0200_0002, 1'b0);
    req(1'b0, 1'b0, 16'h0300, '0, 1'b0);
    idle(2);

    // inputs changed mid-access must not redirect the write
    req(1'b1, 1'b0, 16'h0020, 64'h8888_0008_0008_0008, 1'b0);
    idle(1);
    req(1'b1, 1'b0, 16'h0010, 64'h4444_0004_0004_0004, 1'b1);
    idle(1);
`ifdef UMEM_PROTO_CHK_EN
    chk("proto_err_mid_chg", LW'(proto_err), LW'(1'b1));
`endif
    req(1'b0, 1'b0, 16'h0010, '0, 1'b0);
    idle(1);
    req(1'b0, 1'b0, 16'h0020, '0, 1'b0);
    idle(2);

    // reset during third BUSY cycle aborts the write
    u_we = 1'b1;
    u_re = 1'b0;
    addr = 16'h0104;
    wr_line = 64'h9999_9999_9999_9999;
    a = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    while (cyc < a + 2) @(negedge clk);
    chk("abort_busy_before", LW'(busy), LW'(1'b1));
    rst_n = 1'b0;
    u_we = 1'b0;
    last_rd = '0;
    @(negedge clk);
    chk("abort_busy_after", LW'(busy), LW'(1'b0));
    chk("abort_u_rdy", LW'(u_rdy), LW'(1'b0));
    chk("abort_rd_line", rd_line, '0);
    chk("abort_proto_err", LW'(proto_err), LW'(1'b0));
    rst_n = 1'b1;
    free_edge = cyc + 1;
    idle(LAT + 3);
    req(1'b0, 1'b0, 16'h0105, '0, 1'b0);
    idle(1);

    // both strobes high for one cycle: treated as a write
    req(1'b1, 1'b1, 16'h0400, 64'h0123_4567_89AB_CDEF, 1'b0);
    idle(1);
`ifdef UMEM_PROTO_CHK_EN
    chk("proto_err_both", LW'(proto_err), LW'(1'b1));
`endif
    req(1'b0, 1'b0, 16'h0402, '0, 1'b0);

    // randomized traffic over a small line window, variable gaps
    for (int i = 0; i < 40; i++) begin
      int             idx;
      logic [AW-1:0]  ra;
      bit             wr;
      idx = int'($urandom_range(0, 15));
      ra = 16'h1000 + AW'(idx * 4) + AW'($urandom_range(0, 3));
      wr = !mem_m.exists(int'(ra[AW-1:2])) || ($urandom_range(0, 1) == 1);
      req(wr, 1'b0, ra, {$urandom, $urandom}, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end

    idle(LAT + 4);
    chk("queue_drained", LW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
